// File: rtl/de1_blinker_pio_blink.sv
// de1_blinker_pio_blink
//
// Avalon-MM output PIO with a per-bit blink overlay. A free-running prescaler
// toggles a shared phase bit every PERIOD+1 clocks; each out_port bit whose
// BLINK_EN bit is set is inverted while the phase is high.
//
// Register map (word address):
//   0 DATA       R/W  static output value
//   1 BLINK_EN   R/W  per-bit blink enable
//   2 PERIOD     R/W  terminal count, write also clears the prescaler
//   3 STATUS     R    bit0 = phase; any write resyncs (cnt = 0, phase = 0)
//   4 OUTSET     W    data |= wd
//   5 OUTCLEAR   W    data &= ~wd
//   6 OUTTOGGLE  W    data ^= wd
//   7 reserved
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high
//   address    register word address
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   readdata   combinational read data, zero wait states
//   out_port   driven pins
module de1_blinker_pio_blink #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter int unsigned           CNT_W       = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             write;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] blink_en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt;
  logic             phase;

  assign write = chipselect & ~write_n;
  assign wd    = writedata[WIDTH-1:0];

  // Bits of writedata above WIDTH/CNT_W are intentionally dropped.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data     <= RESET_VALUE;
      blink_en <= '0;
      period   <= '1;
      cnt      <= '0;
      phase    <= 1'b0;
    end else begin
      if (write) begin
        case (address)
          3'd0:    data     <= wd;
          3'd1:    blink_en <= wd;
          3'd2:    period   <= writedata[CNT_W-1:0];
          3'd4:    data     <= data | wd;
          3'd5:    data     <= data & ~wd;
          3'd6:    data     <= data ^ wd;
          default: ;
        endcase
      end

      // Resync beats a PERIOD write, which beats the terminal count.
      // A PERIOD write restarts the count but keeps the current phase.
      if (write && address == 3'd3) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (write && address == 3'd2) begin
        cnt <= '0;
      end else if (cnt >= period) begin
        // >= keeps a shrunk period from wrapping through 2^CNT_W.
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = data;
      3'd1:    readdata[WIDTH-1:0] = blink_en;
      3'd2:    readdata[CNT_W-1:0] = period;
      3'd3:    readdata[0]         = phase;
      default: ;
    endcase
  end

  // Non-blinking bits pass data straight through, so they never glitch.
  assign out_port = data ^ (blink_en & {WIDTH{phase}});

endmodule

// File: tb/tb_de1_blinker_pio_blink.sv
module tb_de1_blinker_pio_blink;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // Instance A: WIDTH=8, RESET_VALUE=0xA5, CNT_W=24
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  // Instance B: WIDTH=32, CNT_W=1
  logic [2:0]  b_address = '0;
  logic        b_chipselect = 1'b0;
  logic        b_write_n = 1'b1;
  logic [31:0] b_writedata = '0;
  logic [31:0] b_readdata;
  logic [31:0] b_out_port;

  always #5 clk = ~clk;

  de1_blinker_pio_blink #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5),
    .CNT_W      (24)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  de1_blinker_pio_blink #(
    .WIDTH      (32),
    .RESET_VALUE(32'h0),
    .CNT_W      (1)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .address   (b_address),
    .chipselect(b_chipselect),
    .write_n   (b_write_n),
    .writedata (b_writedata),
    .readdata  (b_readdata),
    .out_port  (b_out_port)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the phase is derived arithmetically from the number of
  // edges since the prescaler was last restarted.
  logic [7:0]        m_data;
  logic [7:0]        m_blink;
  longint unsigned   m_period;
  longint unsigned   m_cyc;
  longint unsigned   m_start;
  bit                m_phase0;

  function automatic bit model_phase();
    longint unsigned toggles;
    toggles = (m_cyc - m_start) / (m_period + 1);
    return m_phase0 ^ toggles[0];
  endfunction

  task automatic model_reset();
    m_data   = 8'hA5;
    m_blink  = 8'h00;
    m_period = 64'h00FF_FFFF;
    m_cyc    = 0;
    m_start  = 0;
    m_phase0 = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] a, input logic c, input logic wn,
                            input logic [31:0] d);
    bit p;
    p = model_phase();
    m_cyc++;
    if (c && !wn) begin
      case (a)
        3'd0: m_data = d[7:0];
        3'd1: m_blink = d[7:0];
        3'd2: begin m_period = longint'(d[23:0]); m_start = m_cyc; m_phase0 = p; end
        3'd3: begin m_start = m_cyc; m_phase0 = 1'b0; end
        3'd4: m_data = m_data | d[7:0];
        3'd5: m_data = m_data & ~d[7:0];
        3'd6: m_data = m_data ^ d[7:0];
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, m_data};
      3'd1:    return {24'h0, m_blink};
      3'd2:    return {8'h0, m_period[23:0]};
      3'd3:    return {31'h0, model_phase()};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] exp_out();
    return m_data ^ (m_blink & {8{model_phase()}});
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [2:0] a, input logic c, input logic wn, input logic [31:0] d);
    address = a; chipselect = c; write_n = wn; writedata = d;
    #1 check("readdata", readdata, exp_rd(a));
    @(posedge clk);
    model_step(a, c, wn, d);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    check("out_port", {24'h0, out_port}, {24'h0, exp_out()});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(a, 1'b1, 1'b0, d);
  endtask

  task automatic idle(input logic [2:0] a);
    step(a, 1'b0, 1'b1, $urandom);
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1 check(name, readdata, exp);
  endtask

  task automatic step_b(input logic [2:0] a, input logic c, input logic [31:0] d);
    b_address = a; b_chipselect = c; b_write_n = ~c; b_writedata = d;
    @(posedge clk);
    @(negedge clk);
    b_chipselect = 1'b0; b_write_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  waddr;
    logic [31:0] wd;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{3'd0, 32'h0000_000F, 3'd0, 32'h0000_000F};
    tbl[1] = '{3'd4, 32'h0000_0030, 3'd0, 32'h0000_003F};
    tbl[2] = '{3'd5, 32'h0000_0003, 3'd0, 32'h0000_003C};
    tbl[3] = '{3'd6, 32'h0000_0081, 3'd0, 32'h0000_00BD};
    tbl[4] = '{3'd1, 32'hFFFF_FF5A, 3'd1, 32'h0000_005A};
    tbl[5] = '{3'd7, 32'h0000_00FF, 3'd0, 32'h0000_00BD};
    tbl[6] = '{3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0000_0000};
    tbl[7] = '{3'd2, 32'hAB00_0007, 3'd2, 32'h0000_0007};
    tbl[8] = '{3'd3, 32'hFFFF_FFFF, 3'd0, 32'h0000_00BD};
    tbl[9] = '{3'd1, 32'h0000_0000, 3'd1, 32'h0000_0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset out_port", {24'h0, out_port}, 32'h0000_00A5);
    rd_check("reset period", 3'd2, 32'h00FF_FFFF);
    rd_check("reset status", 3'd3, 32'h0);
    rd_check("reset blink_en", 3'd1, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Register access table
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].waddr, tbl[i].wd);
      rd_check($sformatf("tbl%0d", i), tbl[i].raddr, tbl[i].exp);
    end

    // Blink timing: PERIOD=3 -> bit0 toggles every 4 clocks
    wr(3'd2, 32'd3);
    wr(3'd1, 32'h01);
    wr(3'd0, 32'h00);
    wr(3'd3, 32'h0);
    check("blink k0", {24'h0, out_port}, 32'h0);
    for (int k = 1; k < 16; k++) begin
      idle(3'd0);
      check($sformatf("blink k%0d", k), {24'h0, out_port}, 32'((k / 4) % 2));
    end

    // Period shrink: toggle exactly 6 edges after the PERIOD=5 write
    wr(3'd2, 32'd100);
    wr(3'd3, 32'h0);
    repeat (50) idle(3'd3);
    wr(3'd2, 32'd5);
    rd_check("shrink k0", 3'd3, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      idle(3'd3);
      rd_check($sformatf("shrink k%0d", k), 3'd3, (k == 6) ? 32'h1 : 32'h0);
    end

    // Resync on the terminal-count edge wins over the toggle
    wr(3'd2, 32'd3);
    wr(3'd3, 32'h0);
    repeat (3) idle(3'd3);
    wr(3'd3, 32'h1234_5678);
    rd_check("resync prio", 3'd3, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      idle(3'd3);
      rd_check($sformatf("resync k%0d", k), 3'd3, (k == 4) ? 32'h1 : 32'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      logic        c;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd2) d = ($urandom_range(0, 9) == 0) ? {8'h0, 24'($urandom_range(20, 200))}
                                                    : 32'($urandom_range(0, 9));
      c = ($urandom_range(0, 3) == 0);
      step(a, c, $urandom_range(0, 1) == 0, d);
    end

    // Asynchronous reset mid-blink; writes ignored while held
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'd2);
    repeat (4) idle(3'd0);
    #2 reset = 1'b1;
    #1 check("async reset out_port", {24'h0, out_port}, 32'h0000_00A5);
    rd_check("async reset period", 3'd2, 32'h00FF_FFFF);
    rd_check("async reset status", 3'd3, 32'h0);
    address = 3'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd_check("write during reset", 3'd0, 32'h0000_00A5);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (6) idle(3'd3);

    // WIDTH=32, CNT_W=1 build with PERIOD=0
    step_b(3'd0, 1'b1, 32'hFFFF_FFFF);
    step_b(3'd1, 1'b1, 32'hFFFF_0000);
    step_b(3'd2, 1'b1, 32'h0);
    step_b(3'd3, 1'b1, 32'h0);
    b_address = 3'd2;
    #1 check("b period", b_readdata, 32'h0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step_b(3'd1, 1'b0, 32'h0);
      #1 check($sformatf("b out k%0d", k), b_out_port,
               (k % 2 == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
    end
    b_address = 3'd1;
    #1 check("b blink_en", b_readdata, 32'hFFFF_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
